// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared state encoding, default sizing and counter-width helper for the TX slot arbiter
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TX    = 2'd1,
        GUARD = 2'd2
    } state_e;

    localparam int DefNumReq   = 4;
    localparam int DefBurstLen = 10;
    localparam int DefGuardLen = 5;

    function automatic int cnt_w(input int burst_len, input int guard_len);
        return $clog2((burst_len > guard_len ? burst_len : guard_len) + 1);
    endfunction

endpackage

// File: rtl/tx_slot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after the pointer wins
module rr_pick #(
    parameter int NumReq = 4
) (
    input  logic [NumReq-1:0]         req_i,
    input  logic [$clog2(NumReq)-1:0] ptr_i,
    output logic                      valid_o,
    output logic [$clog2(NumReq)-1:0] idx_o
);

    localparam int IW = $clog2(NumReq);

    logic [NumReq-1:0] rot;
    int                sum;

    assign rot = NumReq'({req_i, req_i} >> ptr_i);

    // scan the rotated vector from the far end so the lowest offset from the pointer wins
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        sum     = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            sum = int'(ptr_i) + k;
            if (rot[k]) idx_o = IW'(sum >= NumReq ? sum - NumReq : sum);
        end
    end

endmodule

// File: rtl/tx_slot_arbiter.sv
// tx_slot_arbiter: round-robin TX burst scheduler with guard gap and hit pulse; TX_SLOT_HIT_CNT_EN enables the saturating completed-burst counter
module tx_slot_arbiter
    import tx_sched_pkg::*;
#(
    parameter int NumReq   = DefNumReq,
    parameter int BurstLen = DefBurstLen,
    parameter int GuardLen = DefGuardLen,
    parameter int CntW     = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NumReq-1:0]         i_req,
    output logic [NumReq-1:0]         o_gnt,
    output logic [$clog2(NumReq)-1:0] o_owner,
    output logic                      o_tx_ena_n,
    output logic                      o_hit_pulse,
    output logic                      o_busy,
    output logic [CntW-1:0]           o_hit_total
);

    localparam int IW = $clog2(NumReq);
    localparam int CW = cnt_w(BurstLen, GuardLen);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d, owner_q, owner_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic              ena_n_q, ena_n_d, hit_q, hit_d, busy_q, busy_d;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic              owner_req, burst_end, guard_end;

    rr_pick #(.NumReq(NumReq)) u_pick (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign owner_req = i_req[owner_q];
    assign burst_end = cnt_q == CW'(BurstLen - 1);
    assign guard_end = cnt_q == CW'(GuardLen - 1);

    // next state: grant in IDLE, abort takes precedence over normal end in TX, fixed-length GUARD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        ena_n_d = ena_n_q;
        hit_d   = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (pick_valid) begin
                state_d = TX;
                cnt_d   = '0;
                gnt_d   = NumReq'(1) << pick_idx;
                owner_d = pick_idx;
                ena_n_d = 1'b0;
                busy_d  = 1'b1;
                ptr_d   = pick_idx == IW'(NumReq - 1) ? '0 : pick_idx + 1'b1;
            end
            TX: if (!owner_req || burst_end) begin
                state_d = GUARD;
                cnt_d   = '0;
                gnt_d   = '0;
                ena_n_d = 1'b1;
                hit_d   = owner_req;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            GUARD: if (guard_end) begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ena_n_q <= 1'b1;
            hit_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ena_n_q <= ena_n_d;
            hit_q   <= hit_d;
            busy_q  <= busy_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_owner     = owner_q;
    assign o_tx_ena_n  = ena_n_q;
    assign o_hit_pulse = hit_q;
    assign o_busy      = busy_q;

`ifdef TX_SLOT_HIT_CNT_EN
    logic [CntW-1:0] total_q;

    // count each hit pulse cycle, holding at all-ones
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) total_q <= '0;
        else if (hit_q && !(&total_q)) total_q <= total_q + 1'b1;
    end

    assign o_hit_total = total_q;
`else
    assign o_hit_total = '0;
`endif

endmodule

// File: tb/tb_tx_slot_arbiter.sv
// tb_tx_slot_arbiter: scoreboard bench, expected bursts queued by each scenario and checked by a burst monitor
module tb_tx_slot_arbiter;

    localparam int N  = 4;
    localparam int BL = 10;
    localparam int GL = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  o_gnt;
    logic [1:0]    o_owner;
    logic          o_tx_ena_n, o_hit_pulse, o_busy;
    logic [CW-1:0] o_hit_total;

    tx_slot_arbiter #(.NumReq(N), .BurstLen(BL), .GuardLen(GL), .CntW(CW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .o_gnt       (o_gnt),
        .o_owner     (o_owner),
        .o_tx_ena_n  (o_tx_ena_n),
        .o_hit_pulse (o_hit_pulse),
        .o_busy      (o_busy),
        .o_hit_total (o_hit_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;
        int len;
        bit hit;
    } burst_t;

    burst_t exp_q[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     run = 0;

    // burst monitor: grant/owner each TX cycle, then length and hit pulse when the burst ends
    always @(negedge clk) begin
        burst_t e;
        if (o_tx_ena_n === 1'b0) begin
            run++;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL burst_unexpected: gnt=%b owner=%0d with no burst expected", o_gnt, o_owner);
            end else if ({o_gnt, o_owner, o_hit_pulse} !== {N'(1 << exp_q[0].owner), 2'(exp_q[0].owner), 1'b0}) begin
                n_fail++;
                $display("FAIL burst_grant: gnt=%b owner=%0d hit=%b, want gnt=%b owner=%0d hit=0",
                         o_gnt, o_owner, o_hit_pulse, N'(1 << exp_q[0].owner), exp_q[0].owner);
            end
        end else if (run > 0) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL burst_end: burst of %0d cycles ended with no burst expected", run);
            end else begin
                e = exp_q.pop_front();
                if (run != e.len || o_hit_pulse !== e.hit) begin
                    n_fail++;
                    $display("FAIL burst_end: owner %0d len=%0d hit=%b, want len=%0d hit=%b",
                             e.owner, run, o_hit_pulse, e.len, e.hit);
                end
            end
            run = 0;
        end else begin
            n_chk++;
            if (o_hit_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL hit_spurious: hit=%b outside first guard cycle, want 0", o_hit_pulse);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_hit();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_hit_pulse === 1'b1) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_hit: no hit pulse within 100 cycles, want one");
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_busy === 1'b1) seen = 1'b1;
            if (seen && o_busy === 1'b0) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_done: busy=%b after 200 cycles, want 0", o_busy);
    endtask

    task automatic test_reset();
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if ({o_tx_ena_n, o_gnt, o_busy, o_hit_pulse, o_owner, o_hit_total} !== {1'b1, 4'b0, 1'b0, 1'b0, 2'd0, 3'd0}) begin
                n_fail++;
                $display("FAIL reset_values: ena_n=%b gnt=%b busy=%b hit=%b owner=%0d total=%0d, want 1 0000 0 0 0 0",
                         o_tx_ena_n, o_gnt, o_busy, o_hit_pulse, o_owner, o_hit_total);
            end
        end
        req = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [20:1] ena, hit, ena_x, hit_x;
        exp_q.push_back('{0, BL, 1'b1});
        exp_q.push_back('{0, 4, 1'b0});
        @(posedge clk);
        #1 req = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ena[k]   = o_tx_ena_n;
            hit[k]   = o_hit_pulse;
            ena_x[k] = !((k >= 2 && k <= 11) || k >= 18);
            hit_x[k] = (k == 12);
        end
        n_chk++;
        if (ena !== ena_x) begin
            n_fail++;
            $display("FAIL single_ena_timing: ena_n k1..20=%b, want %b", ena, ena_x);
        end
        n_chk++;
        if (hit !== hit_x) begin
            n_fail++;
            $display("FAIL single_hit_timing: hit k1..20=%b, want %b", hit, hit_x);
        end
        @(posedge clk);
        #1 req = '0;
        wait_done();
    endtask

    task automatic test_round_robin();
        int bad = 0;
        int first_bad = 0;
        logic want;
        do_reset();
        for (int b = 0; b < 5; b++) exp_q.push_back('{b % N, BL, 1'b1});
        @(posedge clk);
        #1 req = 4'b1111;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            want = !(k >= 2 && ((k - 2) % 16) < 10);
            if (o_tx_ena_n !== want) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        @(posedge clk);
        #1 req = '0;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rr_window_gap: %0d cycles off the 10-low/6-high pattern (first at k=%0d), want 0", bad, first_bad);
        end
        wait_done();
    endtask

    task automatic test_contention();
        logic [27:1] busy, ena, busy_x, ena_x;
        do_reset();
        exp_q.push_back('{0, BL, 1'b1});
        exp_q.push_back('{2, 4, 1'b0});
        @(posedge clk);
        #1 req = 4'b0101;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            busy[k]   = o_busy;
            ena[k]    = o_tx_ena_n;
            busy_x[k] = !(k == 1 || k == 17 || k == 27);
            ena_x[k]  = !((k >= 2 && k <= 11) || (k >= 18 && k <= 21));
            if (k == 21) #1 req = '0;
        end
        n_chk++;
        if (busy !== busy_x) begin
            n_fail++;
            $display("FAIL contention_busy: busy k1..27=%b, want %b", busy, busy_x);
        end
        n_chk++;
        if (ena !== ena_x) begin
            n_fail++;
            $display("FAIL contention_ena: ena_n k1..27=%b, want %b", ena, ena_x);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_q.push_back('{0, 5, 1'b0});
        @(posedge clk);
        #1 req = 4'b0001;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({o_tx_ena_n, o_gnt, o_busy, o_hit_pulse} !== {1'b1, 4'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: ena_n=%b gnt=%b busy=%b hit=%b, want 1 0000 0 0",
                     o_tx_ena_n, o_gnt, o_busy, o_hit_pulse);
        end
        req = 4'b1000;
        exp_q.push_back('{3, BL, 1'b1});
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_hit();
        #1 req = '0;
        wait_done();
        n_chk++;
        if (o_owner !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_owner: owner=%0d after release, want 3", o_owner);
        end
    endtask

    task automatic test_counter();
        logic [CW-1:0] want;
        do_reset();
        for (int b = 0; b < 9; b++) exp_q.push_back('{0, BL, 1'b1});
        @(posedge clk);
        #1 req = 4'b0001;
        for (int b = 1; b <= 9; b++) begin
            wait_hit();
            @(negedge clk);
`ifdef TX_SLOT_HIT_CNT_EN
            want = CW'(b > 7 ? 7 : b);
`else
            want = '0;
`endif
            n_chk++;
            if (o_hit_total !== want) begin
                n_fail++;
                $display("FAIL hit_total: after burst %0d total=%0d, want %0d", b, o_hit_total, want);
            end
            if (b == 9) #1 req = '0;
        end
        wait_done();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_contention();
        test_reset_mid();
        test_counter();
        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bursts_missing: %0d expected bursts never seen, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
